// File: rtl/draw_scheduler_pkg.sv
// draw_sched_pkg: shared state encoding, default widths and layer indices for draw_scheduler
package draw_sched_pkg;
  typedef enum logic [2:0] {IDLE, SEEK, DRAW, RELEASE, FDONE} state_t;
  localparam int DEF_X_W = 9;
  localparam int DEF_Y_W = 8;
  localparam int DEF_C_W = 12;
  localparam logic [11:0] DEF_TRANSPARENT = 12'h000;
  localparam int BG = 0;
  localparam int GOLD = 1;
  localparam int STONE = 2;
  localparam int HOOK = 3;
endpackage

// File: rtl/draw_scheduler_if.sv
// draw_scheduler_if: drawer-side and VGA-side signals of the frame scheduler
interface draw_scheduler_if #(
  parameter int NUM_LAYERS = 4,
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int C_W = 12
);
  logic frame;
  logic [NUM_LAYERS-1:0] layer_en;
  logic [NUM_LAYERS-1:0] grant;
  logic [NUM_LAYERS-1:0] layer_done;
  logic [NUM_LAYERS*X_W-1:0] x_in;
  logic [NUM_LAYERS*Y_W-1:0] y_in;
  logic [NUM_LAYERS*C_W-1:0] c_in;
  logic [NUM_LAYERS-1:0] we_in;
  logic [X_W-1:0] x_out;
  logic [Y_W-1:0] y_out;
  logic [C_W-1:0] c_out;
  logic we_out;
  logic busy;
  logic frame_done;
  logic overrun;
  logic wd_err;
  modport master (
    output frame, layer_en, layer_done, x_in, y_in, c_in, we_in,
    input grant, x_out, y_out, c_out, we_out, busy, frame_done, overrun, wd_err
  );
  modport slave (
    input frame, layer_en, layer_done, x_in, y_in, c_in, we_in,
    output grant, x_out, y_out, c_out, we_out, busy, frame_done, overrun, wd_err
  );
endinterface

// File: rtl/draw_scheduler_pixel_port_mux.sv
// pixel_port_mux: registered layer select onto the pixel port with transparency filtering
module pixel_port_mux
  import draw_sched_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int X_W = DEF_X_W,
  parameter int Y_W = DEF_Y_W,
  parameter int C_W = DEF_C_W,
  parameter logic [C_W-1:0] TRANSPARENT = C_W'(DEF_TRANSPARENT),
  parameter logic [NUM_LAYERS-1:0] OPAQUE_MASK = NUM_LAYERS'(1),
  parameter int IW = NUM_LAYERS > 1 ? $clog2(NUM_LAYERS) : 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic [IW-1:0] idx,
  input  logic sel_valid,
  input  logic [NUM_LAYERS*X_W-1:0] x_in,
  input  logic [NUM_LAYERS*Y_W-1:0] y_in,
  input  logic [NUM_LAYERS*C_W-1:0] c_in,
  input  logic [NUM_LAYERS-1:0] we_in,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [C_W-1:0] c_out,
  output logic we_out
);
  logic [C_W-1:0] c_sel;
  assign c_sel = c_in[int'(idx)*C_W +: C_W];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      x_out <= '0;
      y_out <= '0;
      c_out <= '0;
      we_out <= 1'b0;
    end else begin
      we_out <= sel_valid && we_in[idx] && (c_sel != TRANSPARENT || OPAQUE_MASK[idx]);
      if (sel_valid) begin
        x_out <= x_in[int'(idx)*X_W +: X_W];
        y_out <= y_in[int'(idx)*Y_W +: Y_W];
        c_out <= c_sel;
      end
    end
endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: per-frame back-to-front layer sequencer owning the VGA pixel port (watchdog: DRAW_SCHEDULER_WATCHDOG_EN)
module draw_scheduler
  import draw_sched_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int X_W = DEF_X_W,
  parameter int Y_W = DEF_Y_W,
  parameter int C_W = DEF_C_W,
  parameter logic [C_W-1:0] TRANSPARENT = C_W'(DEF_TRANSPARENT),
  parameter logic [NUM_LAYERS-1:0] OPAQUE_MASK = NUM_LAYERS'(1),
  parameter logic [16:0] WD_CYCLES = 17'd100000
) (
  input logic clk,
  input logic resetn,
  draw_scheduler_if.slave bus
);
  localparam int IW = NUM_LAYERS > 1 ? $clog2(NUM_LAYERS) : 1;
  state_t state;
  logic [NUM_LAYERS-1:0] mask, grant;
  logic [IW-1:0] idx;
  logic busy, frame_done, overrun, wd_hit, last;
  assign last = idx == IW'(NUM_LAYERS - 1);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      mask <= '0;
      idx <= '0;
      grant <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (bus.frame && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE:
          if (bus.frame) begin
            mask <= bus.layer_en;
            idx <= '0;
            busy <= 1'b1;
            state <= SEEK;
          end
        SEEK:
          if (mask[idx]) begin
            grant <= NUM_LAYERS'(1) << idx;
            state <= DRAW;
          end else if (last) begin
            frame_done <= 1'b1;
            state <= FDONE;
          end else idx <= idx + 1'b1;
        DRAW:
          if (bus.layer_done[idx] || wd_hit) begin
            grant <= '0;
            state <= RELEASE;
          end
        RELEASE:
          if (last) begin
            frame_done <= 1'b1;
            state <= FDONE;
          end else begin
            idx <= idx + 1'b1;
            state <= SEEK;
          end
        default: begin
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
`ifdef DRAW_SCHEDULER_WATCHDOG_EN
  logic [16:0] wd_cnt;
  logic wd_err;
  assign wd_hit = state == DRAW && wd_cnt == WD_CYCLES - 17'd1 && !bus.layer_done[idx];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else begin
      wd_cnt <= state == DRAW ? wd_cnt + 17'd1 : '0;
      wd_err <= wd_err | wd_hit;
    end
  assign bus.wd_err = wd_err;
`else
  assign wd_hit = 1'b0;
  assign bus.wd_err = 1'b0;
`endif
  assign bus.grant = grant;
  assign bus.busy = busy;
  assign bus.frame_done = frame_done;
  assign bus.overrun = overrun;
  pixel_port_mux #(
    .NUM_LAYERS(NUM_LAYERS), .X_W(X_W), .Y_W(Y_W), .C_W(C_W),
    .TRANSPARENT(TRANSPARENT), .OPAQUE_MASK(OPAQUE_MASK), .IW(IW)
  ) u_mux (
    .clk(clk), .resetn(resetn), .idx(idx), .sel_valid(state == DRAW),
    .x_in(bus.x_in), .y_in(bus.y_in), .c_in(bus.c_in), .we_in(bus.we_in),
    .x_out(bus.x_out), .y_out(bus.y_out), .c_out(bus.c_out), .we_out(bus.we_out)
  );
endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: directed self-checking bench for draw_scheduler
module tb_draw_scheduler;
  logic clk, resetn;
  int vectors = 0, miscompares = 0, we_cnt = 0, fd_cnt = 0;
  logic [3:0] grant_or = '0;
  draw_scheduler_if #(.NUM_LAYERS(4), .X_W(9), .Y_W(8), .C_W(12)) bus ();
  draw_scheduler dut (.clk(clk), .resetn(resetn), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.we_out) we_cnt++;
    if (bus.frame_done) fd_cnt++;
    grant_or |= bus.grant;
  endtask
  task automatic clear_inputs();
    bus.frame = 1'b0;
    bus.layer_en = '0;
    bus.layer_done = '0;
    bus.x_in = '0;
    bus.y_in = '0;
    bus.c_in = '0;
    bus.we_in = '0;
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    tick();
    resetn = 1'b1;
    tick();
  endtask
  task automatic start_frame(input logic [3:0] en);
    bus.frame = 1'b1;
    bus.layer_en = en;
    tick();
    bus.frame = 1'b0;
  endtask
  task automatic wait_fd();
    int w = 0;
    while (!bus.frame_done && w < 20) begin
      tick();
      w++;
    end
    chk("frame_done", {31'd0, bus.frame_done}, 32'd1);
  endtask
  // waits for this layer's grant, then streams n pixels with done on the last one
  task automatic draw_layer(input int l, input int n, input logic [11:0] c, input logic we);
    int w = 0;
    logic [3:0] exp_g = 4'd1 << l;
    while (bus.grant !== exp_g && w < 20) begin
      tick();
      w++;
    end
    chk($sformatf("grant_l%0d", l), {28'd0, bus.grant}, {28'd0, exp_g});
    for (int p = 0; p < n; p++) begin
      bus.we_in[l] = we;
      bus.c_in[l*12 +: 12] = c;
      bus.x_in[l*9 +: 9] = 9'(p + l * 16);
      bus.y_in[l*8 +: 8] = 8'(l + 100);
      bus.layer_done[l] = p == n - 1;
      tick();
    end
    bus.we_in = '0;
    bus.layer_done = '0;
    chk($sformatf("release_grant_l%0d", l), {28'd0, bus.grant}, 32'd0);
    chk($sformatf("x_out_l%0d", l), {23'd0, bus.x_out}, 32'(n - 1 + l * 16));
    chk($sformatf("y_out_l%0d", l), {24'd0, bus.y_out}, 32'(l + 100));
    chk($sformatf("c_out_l%0d", l), {20'd0, bus.c_out}, {20'd0, c});
    chk($sformatf("we_out_l%0d", l), {31'd0, bus.we_out}, {31'd0, we && (c != 12'h000 || l == 0)});
  endtask
  initial begin
    resetn = 1'b0;
    clear_inputs();
    #1;
    chk("rst_grant", {28'd0, bus.grant}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_we", {31'd0, bus.we_out}, 32'd0);
    chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    start_frame(4'b0010);
    tick();
    tick();
    chk("mid_grant", {28'd0, bus.grant}, 32'h2);
    bus.we_in[1] = 1'b1;
    bus.c_in[12 +: 12] = 12'h0f0;
    tick();
    chk("mid_we", {31'd0, bus.we_out}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("async_grant", {28'd0, bus.grant}, 32'd0);
    chk("async_we", {31'd0, bus.we_out}, 32'd0);
    chk("async_busy", {31'd0, bus.busy}, 32'd0);
    clear_inputs();
    tick();
    resetn = 1'b1;
    tick();
    we_cnt = 0;
    grant_or = '0;
    start_frame(4'b0001);
    draw_layer(0, 3, 12'h0ab, 1'b1);
    wait_fd();
    chk("l0_only_grants", {28'd0, grant_or}, 32'h1);
    chk("l0_only_we", 32'(we_cnt), 32'd3);
    do_reset();
    we_cnt = 0;
    fd_cnt = 0;
    start_frame(4'b1111);
    chk("busy_on", {31'd0, bus.busy}, 32'd1);
    for (int l = 0; l < 4; l++) draw_layer(l, 5, 12'h123, 1'b1);
    wait_fd();
    tick();
    chk("all_busy_off", {31'd0, bus.busy}, 32'd0);
    chk("all_fd_once", 32'(fd_cnt), 32'd1);
    chk("all_we_count", 32'(we_cnt), 32'd20);
    we_cnt = 0;
    start_frame(4'b0011);
    draw_layer(0, 2, 12'h000, 1'b1);
    draw_layer(1, 2, 12'h000, 1'b1);
    wait_fd();
    chk("transp_we_count", 32'(we_cnt), 32'd2);
    tick();
    grant_or = '0;
    start_frame(4'b0000);
    repeat (3) tick();
    chk("empty_fd_early", {31'd0, bus.frame_done}, 32'd0);
    tick();
    chk("empty_fd_at5", {31'd0, bus.frame_done}, 32'd1);
    chk("empty_no_grant", {28'd0, grant_or}, 32'd0);
    tick();
    chk("empty_busy_off", {31'd0, bus.busy}, 32'd0);
    chk("no_overrun_yet", {31'd0, bus.overrun}, 32'd0);
    start_frame(4'b0110);
    tick();
    tick();
    chk("ovr_grant1", {28'd0, bus.grant}, 32'h2);
    bus.frame = 1'b1;
    bus.layer_done[2] = 1'b1;
    tick();
    bus.frame = 1'b0;
    bus.layer_done = '0;
    chk("stray_done_ignored", {28'd0, bus.grant}, 32'h2);
    chk("overrun_draw", {31'd0, bus.overrun}, 32'd1);
    bus.layer_done[1] = 1'b1;
    tick();
    bus.layer_done = '0;
    chk("ovr_release", {28'd0, bus.grant}, 32'd0);
    draw_layer(2, 1, 12'h456, 1'b1);
    wait_fd();
    do_reset();
    start_frame(4'b0000);
    repeat (4) tick();
    chk("fdone_state", {31'd0, bus.frame_done}, 32'd1);
    bus.frame = 1'b1;
    tick();
    bus.frame = 1'b0;
    chk("overrun_fdone", {31'd0, bus.overrun}, 32'd1);
    chk("fdone_frame_ignored", {31'd0, bus.busy}, 32'd0);
    tick();
    chk("still_idle", {31'd0, bus.busy}, 32'd0);
    chk("wd_err_off", {31'd0, bus.wd_err}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
- Frame-level sequencer and arbiter for the single VGA pixel-write port.
- On each frame tick, walks the enabled drawing layers in fixed back-to-front order (background, gold, stone, hook, ...).
- Grants the port to exactly one layer drawer at a time, using an enable/done handshake, and forwards that drawer's pixels.
- Sits between the per-object draw FSMs and the VGA adapter.
- Replaces ad-hoc priority muxing in the top-level view.

Parameters:
- NUM_LAYERS, 4: number of drawer requesters; index 0 is drawn first (backmost).
- X_W, 9: pixel X width.
- Y_W, 8: pixel Y width.
- C_W, 12: colour width (RGB444).
- TRANSPARENT, 12'h000: colour value treated as "do not write".
- OPAQUE_MASK, 4'b0001: per-layer bit; when set, that layer's transparent pixels are still written (background).
- WD_CYCLES, 17'd100000: watchdog limit per layer grant (optional feature).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- frame  in  1  one-cycle frame tick from rate divider
- layer_en  in  NUM_LAYERS  layers to draw this frame; sampled at frame start
- grant  out  NUM_LAYERS  one-hot draw enable to the drawer FSMs
- layer_done  in  NUM_LAYERS  one-cycle done pulse from each drawer
- x_in  in  NUM_LAYERS*X_W  flattened drawer X buses; layer i at [i*X_W +: X_W]
- y_in  in  NUM_LAYERS*Y_W  flattened drawer Y buses
- c_in  in  NUM_LAYERS*C_W  flattened drawer colour buses
- we_in  in  NUM_LAYERS  drawer write strobes
- x_out  out  X_W  to VGA adapter
- y_out  out  Y_W  to VGA adapter
- c_out  out  C_W  to VGA adapter
- we_out  out  1  to VGA adapter
- busy  out  1  high from frame accept until frame_done
- frame_done  out  1  one-cycle pulse after the last layer finishes
- overrun  out  1  sticky; set when a frame tick arrives while not IDLE
- wd_err  out  1  sticky watchdog error (0 when feature off)

Behaviour:
- Reset: asynchronous, immediate in any state. State IDLE; all outputs 0; latched mask 0; layer index 0.
- States: IDLE, SEEK, DRAW, RELEASE, FDONE.
- IDLE: on frame=1, latch mask<=layer_en, idx<=0, busy<=1, go to SEEK.
- SEEK (one cycle per index):
  - If mask[idx]=1, go to DRAW with grant<=onehot(idx).
  - Else if idx==NUM_LAYERS-1, go to FDONE.
  - Else idx<=idx+1.
  - An all-zero mask therefore reaches FDONE after NUM_LAYERS SEEK cycles.
- DRAW: grant held. Port mux is registered with 1-cycle latency:
  - x_out/y_out/c_out <= layer idx inputs.
  - we_out <= we_in[idx] & (c_in[idx]!=TRANSPARENT | OPAQUE_MASK[idx]).
  - The transparency test uses the same-cycle input colour, not the registered output.
- DRAW exit: layer_done[idx]=1 → RELEASE. Pixels presented in the done cycle are still forwarded. layer_done from non-granted layers is ignored.
- RELEASE:
  - One cycle, grant=0 (lets the drawer FSM return to idle), we_out<=0.
  - Then idx==NUM_LAYERS-1 → FDONE; else idx<=idx+1 → SEEK.
- FDONE: frame_done=1 for one cycle, busy<=0, go to IDLE.
- frame=1 in any state other than IDLE:
  - Ignored, and sets overrun (sticky until reset).
  - This includes the FDONE cycle.
- Outside DRAW, we_out=0 and x/y/c hold their last values.
- Widths: idx is clog2(NUM_LAYERS) bits. Bus slicing is constant-width indexed part-select.

Optional Feature:
- Macro: DRAW_SCHEDULER_WATCHDOG_EN.
- When defined:
  - A counter resets on DRAW entry and increments each DRAW cycle.
  - When it reaches WD_CYCLES without layer_done, set wd_err (sticky) and force RELEASE, skipping that layer.
- When undefined: DRAW waits indefinitely; wd_err is tied to 0 and no counter is synthesized.

Decomposition:
- Package draw_sched_pkg holds:
  - the state encoding constants (IDLE..FDONE);
  - default X_W/Y_W/C_W;
  - TRANSPARENT;
  - the layer index assignments (BG=0, GOLD=1, STONE=2, HOOK=3).
- Sub-module: pixel_port_mux. It is the registered NUM_LAYERS:1 select plus the transparency filter, driven by idx and a select-valid signal.

Test Plan:
- Reset mid-DRAW (layer 1 granted, we_out=1) → next sample grant=0, we_out=0, busy=0. After release, frame with layer_en=4'b0001 draws layer 0 only.
- layer_en=4'b1111, each drawer asserts done after 5 pixels → grant sequence 0001, 0010, 0100, 1000, each followed by a 1-cycle gap. frame_done pulses once; exactly 20 we_out pulses.
- Layer 1 emits c_in=12'h000 with we_in=1 → we_out=0. Layer 0 emits c_in=12'h000 → we_out=1 (opaque).
- layer_en=4'b0000 → frame_done exactly NUM_LAYERS+1 cycles after frame; grant never asserted.
- frame pulses during DRAW and during FDONE → overrun=1, schedule unaffected. Stray layer_done[2] while layer 1 is granted → ignored.
- With DRAW_SCHEDULER_WATCHDOG_EN and WD_CYCLES=16, layer 2 never done → wd_err=1 at DRAW cycle 16, then layer 3 is granted after RELEASE.
